// File: rtl/host_cmd_master.sv
// Host-side command initiator: serializes one register/ALU command into a UART byte
// frame, then gathers the response bytes. Optional response watchdog: HOST_CMD_TIMEOUT_EN.
module host_cmd_master #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int ALU_FUN_WIDTH  = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_type,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_data,
  input  logic [DATA_WIDTH-1:0]   cmd_op_b,
  input  logic [ALU_FUN_WIDTH-1:0] cmd_fun,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  input  logic [DATA_WIDTH-1:0]   rx_data,
  input  logic                    rx_valid,
  output logic                    rsp_valid,
  output logic [2*DATA_WIDTH-1:0] rsp_data,
  output logic                    rsp_timeout
);
  typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, RESP} state_t;

  state_t                        state, state_nxt;
  logic [3:0][DATA_WIDTH-1:0]    frame, nf;
  logic [2:0]                    frame_len, nf_len;
  logic [1:0]                    rsp_need, nf_need;
  logic [1:0]                    typ, idx, rx_cnt;
  logic [DATA_WIDTH-1:0]         rx_b0;
  logic                          hs, tx_fire, tx_last, rx_hit, rx_last, tmo;

  assign hs      = cmd_valid && cmd_ready;
  assign tx_fire = (state == SEND) && tx_valid && tx_ready;
  assign tx_last = tx_fire && ((3'(idx) + 3'd1) == frame_len);
  assign rx_hit  = (state == WAIT_RSP) && rx_valid;
  assign rx_last = rx_hit && (2'(rx_cnt + 2'd1) == rsp_need);

  // Frame image built from the live command fields; only captured on handshake.
  always_comb begin
    nf      = '0;
    nf_len  = 3'd2;
    nf_need = 2'd2;
    case (cmd_type)
      2'b00: begin
        nf[0] = DATA_WIDTH'(8'hAA); nf[1] = DATA_WIDTH'(cmd_addr); nf[2] = cmd_data;
        nf_len = 3'd3; nf_need = 2'd0;
      end
      2'b01: begin
        nf[0] = DATA_WIDTH'(8'hBB); nf[1] = DATA_WIDTH'(cmd_addr);
        nf_need = 2'd1;
      end
      2'b10: begin
        nf[0] = DATA_WIDTH'(8'hCC); nf[1] = cmd_data; nf[2] = cmd_op_b;
        nf[3] = DATA_WIDTH'(cmd_fun); nf_len = 3'd4;
      end
      default: begin
        nf[0] = DATA_WIDTH'(8'hDD); nf[1] = DATA_WIDTH'(cmd_fun);
      end
    endcase
  end

`ifdef HOST_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  // Counter sits at 0 outside WAIT_RSP, so it is already cleared on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            tmo_cnt <= '0;
    else if (state != WAIT_RSP || rx_valid) tmo_cnt <= '0;
    else                                   tmo_cnt <= tmo_cnt + 1'b1;
  end
  assign tmo = (state == WAIT_RSP) && !rx_valid && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (hs) state_nxt = SEND;
      SEND:     if (tx_last) state_nxt = (rsp_need == 2'd0) ? RESP : WAIT_RSP;
      WAIT_RSP: if (rx_last) state_nxt = RESP;
                else if (tmo) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame       <= '0;
      frame_len   <= 3'd0;
      rsp_need    <= 2'd0;
      typ         <= 2'd0;
      idx         <= 2'd0;
      rx_cnt      <= 2'd0;
      rx_b0       <= '0;
      cmd_ready   <= 1'b1;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      cmd_ready   <= (state_nxt == IDLE);
      rsp_valid   <= 1'b0;
      rsp_timeout <= tmo;
      if (hs) begin
        frame     <= nf;
        frame_len <= nf_len;
        rsp_need  <= nf_need;
        typ       <= cmd_type;
        idx       <= 2'd0;
        rx_cnt    <= 2'd0;
        tx_valid  <= 1'b1;
        tx_data   <= nf[0];
      end
      if (tx_fire) begin
        idx <= idx + 2'd1;
        if (tx_last) tx_valid <= 1'b0;
        else         tx_data  <= frame[idx + 2'd1];
      end
      if (rx_hit) begin
        rx_cnt <= rx_cnt + 2'd1;
        if (rx_cnt == 2'd0) rx_b0 <= rx_data;
      end
      // The final response byte is still on rx_data at the RESP transition.
      if (state_nxt == RESP && state != RESP) begin
        rsp_valid <= 1'b1;
        case (typ)
          2'b00:   rsp_data <= '0;
          2'b01:   rsp_data <= {{DATA_WIDTH{1'b0}}, rx_data};
          default: rsp_data <= {rx_data, rx_b0};
        endcase
      end
    end
  end
endmodule
